// File: rtl/spi_command_controller_pkg.sv
// rtl/spi_command_controller_pkg.sv - opcodes, state encoding and status layout for the SPI command controller
package spi_command_controller_pkg;

   localparam logic [7:0] CMD_NOP       = 8'h00;
   localparam logic [7:0] CMD_READ_REG  = 8'h01;
   localparam logic [7:0] CMD_WRITE_REG = 8'h02;
   localparam logic [7:0] CMD_READ_FIFO = 8'h03;

   localparam int STAT_EMPTY_BIT     = 0;
   localparam int STAT_UNDERFLOW_BIT = 1;
   localparam int STAT_ERR_BIT       = 2;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_RD_ADDR     = 3'd1,
      ST_WR_ADDR     = 3'd2,
      ST_WR_DATA     = 3'd3,
      ST_FIFO_STREAM = 3'd4,
      ST_DISCARD     = 3'd5
   } state_e;

   // Status byte is {5'b0, err, underflow, fifo_empty}.
   function automatic logic [7:0] status_byte(input logic err,
                                              input logic underflow,
                                              input logic empty);
      logic [7:0] s;
      s = '0;
      s[STAT_ERR_BIT]       = err;
      s[STAT_UNDERFLOW_BIT] = underflow;
      s[STAT_EMPTY_BIT]     = empty;
      return s;
   endfunction

endpackage

// File: rtl/spi_command_controller_if.sv
// rtl/spi_command_controller_if.sv - byte, register-file and FIFO-pop signals of the SPI command controller
interface spi_command_controller_if #(parameter int ADDR_WIDTH = 4);

   logic [7:0]            rx_data;
   logic                  rx_strobe;
   logic [7:0]            tx_data;
   logic                  tx_strobe;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [7:0]            reg_rd_data;
   logic [7:0]            reg_wr_data;
   logic                  reg_wr_strobe;
   logic [7:0]            fifo_rd_data;
   logic                  fifo_empty;
   logic                  fifo_rd_strobe;

   modport master (
      input  rx_data, rx_strobe, reg_rd_data, fifo_rd_data, fifo_empty,
      output tx_data, tx_strobe, reg_addr, reg_wr_data, reg_wr_strobe, fifo_rd_strobe
   );

   modport slave (
      output rx_data, rx_strobe, reg_rd_data, fifo_rd_data, fifo_empty,
      input  tx_data, tx_strobe, reg_addr, reg_wr_data, reg_wr_strobe, fifo_rd_strobe
   );

endinterface

// File: rtl/spi_command_controller_sync.sv
// rtl/spi_command_controller_sync.sv - two-flop synchronizer for asynchronous level inputs
module spi_command_controller_sync #(
   parameter int              WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   // Shift the raw input through two stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer flops; reset value chosen by the instantiating block.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_command_controller.sv
// rtl/spi_command_controller.sv - byte-level command sequencer between the SPI device and register file / FIFO
module spi_command_controller
   import spi_command_controller_pkg::*;
#(
   parameter int         ADDR_WIDTH   = 4,
   parameter logic [7:0] NOP_RESPONSE = 8'h00
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     spi_cs_n,
   spi_command_controller_if.master bus
);

   logic cs_n_sync;

   // Chip select idles high so the block resets into the deselected condition.
   spi_command_controller_sync #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_cs_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (spi_cs_n),
      .q       (cs_n_sync)
   );

   state_e                state_q, state_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_strobe_q, tx_strobe_d;
   logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]            reg_wr_data_q, reg_wr_data_d;
   logic                  reg_wr_strobe_q, reg_wr_strobe_d;
   logic                  fifo_rd_strobe_q, fifo_rd_strobe_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  err_q, err_d;
   logic                  underflow_q, underflow_d;

   logic byte_valid;
   logic addr_ok;
   logic err_set;
   logic underflow_set;
   logic status_load;
   logic fifo_resp;

   // Bytes arriving while deselected are dropped.
   assign byte_valid = !cs_n_sync && bus.rx_strobe;
   // An address byte is in range when no bit at or above ADDR_WIDTH is set.
   assign addr_ok    = ((32'(bus.rx_data) >> ADDR_WIDTH) == 32'd0);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; deselect pulls the sequencer back to IDLE every cycle.
   always_comb begin
      state_d = state_q;
      if (cs_n_sync) begin
         state_d = ST_IDLE;
      end else if (bus.rx_strobe) begin
         case (state_q)
            ST_IDLE: begin
               case (bus.rx_data)
                  CMD_READ_REG:  state_d = ST_RD_ADDR;
                  CMD_WRITE_REG: state_d = ST_WR_ADDR;
                  CMD_READ_FIFO: state_d = ST_FIFO_STREAM;
                  default:       state_d = ST_DISCARD;
               endcase
            end
            ST_RD_ADDR:     state_d = ST_DISCARD;
            ST_WR_ADDR:     state_d = addr_ok ? ST_WR_DATA : ST_DISCARD;
            ST_WR_DATA:     state_d = ST_DISCARD;
            ST_FIFO_STREAM: state_d = ST_FIFO_STREAM;
            ST_DISCARD:     state_d = ST_DISCARD;
            default:        state_d = ST_IDLE;
         endcase
      end
   end

   // Response, side-effect and sticky-flag computation for the byte in flight.
   always_comb begin
      tx_data_d        = tx_data_q;
      tx_strobe_d      = 1'b0;
      reg_addr_d       = reg_addr_q;
      reg_wr_data_d    = reg_wr_data_q;
      reg_wr_strobe_d  = 1'b0;
      fifo_rd_strobe_d = 1'b0;
      rd_pend_d        = 1'b0;
      err_set          = 1'b0;
      underflow_set    = 1'b0;
      status_load      = 1'b0;
      fifo_resp        = 1'b0;

      // Second half of READ_REG: reg_addr settled last cycle, load its data now.
      if (!cs_n_sync && rd_pend_q) begin
         tx_data_d   = bus.reg_rd_data;
         tx_strobe_d = 1'b1;
      end

      if (byte_valid) begin
         tx_strobe_d = 1'b1;
         tx_data_d   = NOP_RESPONSE;
         case (state_q)
            ST_IDLE: begin
               case (bus.rx_data)
                  CMD_NOP, CMD_READ_REG, CMD_WRITE_REG: status_load = 1'b1;
                  CMD_READ_FIFO:                        fifo_resp   = 1'b1;
                  default:                              err_set     = 1'b1;
               endcase
            end
            ST_RD_ADDR: begin
               if (addr_ok) begin
                  reg_addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
                  rd_pend_d   = 1'b1;
                  tx_strobe_d = 1'b0;
                  tx_data_d   = tx_data_q;
               end else begin
                  err_set = 1'b1;
               end
            end
            ST_WR_ADDR: begin
               if (addr_ok) begin
                  reg_addr_d = bus.rx_data[ADDR_WIDTH-1:0];
               end else begin
                  err_set = 1'b1;
               end
            end
            ST_WR_DATA: begin
               reg_wr_data_d   = bus.rx_data;
               reg_wr_strobe_d = 1'b1;
            end
            ST_FIFO_STREAM: fifo_resp = 1'b1;
            default: ;
         endcase

         if (status_load) begin
            tx_data_d = status_byte(err_q, underflow_q, bus.fifo_empty);
         end

         if (fifo_resp) begin
            if (!bus.fifo_empty) begin
               tx_data_d        = bus.fifo_rd_data;
               fifo_rd_strobe_d = 1'b1;
            end else begin
               underflow_set = 1'b1;
            end
         end
      end

      // Reading status clears the sticky flags, but a same-cycle set survives.
      err_d       = err_set       | (err_q       & ~status_load);
      underflow_d = underflow_set | (underflow_q & ~status_load);
   end

   // Output and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_data_q        <= '0;
         tx_strobe_q      <= 1'b0;
         reg_addr_q       <= '0;
         reg_wr_data_q    <= '0;
         reg_wr_strobe_q  <= 1'b0;
         fifo_rd_strobe_q <= 1'b0;
         rd_pend_q        <= 1'b0;
         err_q            <= 1'b0;
         underflow_q      <= 1'b0;
      end else begin
         tx_data_q        <= tx_data_d;
         tx_strobe_q      <= tx_strobe_d;
         reg_addr_q       <= reg_addr_d;
         reg_wr_data_q    <= reg_wr_data_d;
         reg_wr_strobe_q  <= reg_wr_strobe_d;
         fifo_rd_strobe_q <= fifo_rd_strobe_d;
         rd_pend_q        <= rd_pend_d;
         err_q            <= err_d;
         underflow_q      <= underflow_d;
      end
   end

   assign bus.tx_data        = tx_data_q;
   assign bus.tx_strobe      = tx_strobe_q;
   assign bus.reg_addr       = reg_addr_q;
   assign bus.reg_wr_data    = reg_wr_data_q;
   assign bus.reg_wr_strobe  = reg_wr_strobe_q;
   assign bus.fifo_rd_strobe = fifo_rd_strobe_q;

endmodule

// File: tb/tb_spi_command_controller.sv
// tb/tb_spi_command_controller.sv - directed vector bench for spi_command_controller
module tb_spi_command_controller;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic cs_n = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   spi_command_controller_if #(.ADDR_WIDTH(4)) bus();

   spi_command_controller #(
      .ADDR_WIDTH   (4),
      .NOP_RESPONSE (8'h00)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .spi_cs_n (cs_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register file model: combinational read, write on strobe.
   logic [7:0] regs [0:15] = '{default: 8'h00};
   assign bus.reg_rd_data = regs[bus.reg_addr];
   always @(posedge clk) if (bus.reg_wr_strobe) regs[bus.reg_addr] <= bus.reg_wr_data;

   // FIFO model: preloaded with 11, 22; first-word-fall-through.
   localparam int FIFO_FILL = 2;
   logic [7:0] fifo_mem [0:3] = '{8'h11, 8'h22, 8'h00, 8'h00};
   int fifo_rd_ptr = 0;
   assign bus.fifo_empty   = (fifo_rd_ptr >= FIFO_FILL);
   assign bus.fifo_rd_data = bus.fifo_empty ? 8'h00 : fifo_mem[fifo_rd_ptr[1:0]];
   always @(posedge clk) if (bus.fifo_rd_strobe && fifo_rd_ptr < FIFO_FILL) fifo_rd_ptr <= fifo_rd_ptr + 1;

   // Event monitor sampled on the falling edge.
   int         tx_cnt = 0, wr_cnt = 0, pop_cnt = 0, tx_cyc = 0;
   logic [7:0] tx_last = 8'h00, wr_data_last = 8'h00;
   logic [3:0] wr_addr_last = 4'h0;
   always @(negedge clk) begin
      if (bus.tx_strobe === 1'b1) begin
         tx_cnt  <= tx_cnt + 1;
         tx_last <= bus.tx_data;
         tx_cyc  <= cyc;
      end
      if (bus.reg_wr_strobe === 1'b1) begin
         wr_cnt       <= wr_cnt + 1;
         wr_addr_last <= bus.reg_addr;
         wr_data_last <= bus.reg_wr_data;
      end
      if (bus.fifo_rd_strobe === 1'b1) pop_cnt <= pop_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit         new_frame;
      logic [7:0] rx;
      logic [7:0] exp_tx;
      int         exp_lat;
      bit         exp_wr;
      logic [3:0] wr_addr;
      logic [7:0] wr_data;
      int         exp_pops;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit nf, input logic [7:0] rx, input logic [7:0] etx,
                               input int lat, input bit wr, input logic [3:0] wa,
                               input logic [7:0] wd, input int pops);
      vec_t v;
      v.new_frame = nf; v.rx = rx; v.exp_tx = etx; v.exp_lat = lat;
      v.exp_wr = wr; v.wr_addr = wa; v.wr_data = wd; v.exp_pops = pops;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, output int sent_cyc);
      bus.rx_data   = b;
      bus.rx_strobe = 1'b1;
      sent_cyc      = cyc;
      tick(1);
      bus.rx_strobe = 1'b0;
      tick(5);
   endtask

   task automatic start_frame();
      cs_n = 1'b0;
      tick(4);
   endtask

   task automatic end_frame();
      cs_n = 1'b1;
      tick(4);
   endtask

   initial begin
      int sc, tx0, wr0, pop0;
      bus.rx_data   = 8'h00;
      bus.rx_strobe = 1'b0;

      // Reset state.
      tick(3);
      check("reset_outputs",
            {bus.tx_data, bus.tx_strobe, bus.reg_addr, bus.reg_wr_data, bus.reg_wr_strobe, bus.fifo_rd_strobe},
            32'h0);
      reset_n = 1'b1;
      tick(4);

      // {new_frame, rx, expected tx, latency, write?, wr addr, wr data, pops}
      add(1, 8'h02, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h05, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'hA5, 8'h00, 1, 1'b1, 4'h5, 8'hA5, 0);
      add(1, 8'h01, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h05, 8'hA5, 2, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h33, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h7F, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h01, 8'h04, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h1F, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h00, 8'h04, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h00, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h03, 8'h11, 1, 1'b0, 4'h0, 8'h00, 1);
      add(0, 8'hAA, 8'h22, 1, 1'b0, 4'h0, 8'h00, 1);
      add(0, 8'hBB, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h00, 8'h03, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h00, 8'h01, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h02, 8'h01, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h0F, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h5A, 8'h00, 1, 1'b1, 4'hF, 8'h5A, 0);
      add(1, 8'h01, 8'h01, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h0F, 8'h5A, 2, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h02, 8'h01, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h10, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(0, 8'h77, 8'h00, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h00, 8'h05, 1, 1'b0, 4'h0, 8'h00, 0);
      add(1, 8'h00, 8'h01, 1, 1'b0, 4'h0, 8'h00, 0);

      foreach (vecs[i]) begin
         if (vecs[i].new_frame) begin
            end_frame();
            start_frame();
         end
         tx0 = tx_cnt; wr0 = wr_cnt; pop0 = pop_cnt;
         send_byte(vecs[i].rx, sc);
         check($sformatf("vec%0d_tx_count", i), tx_cnt - tx0, 1);
         check($sformatf("vec%0d_tx_data", i), tx_last, vecs[i].exp_tx);
         check($sformatf("vec%0d_latency", i), tx_cyc - sc, vecs[i].exp_lat);
         check($sformatf("vec%0d_wr_count", i), wr_cnt - wr0, vecs[i].exp_wr ? 1 : 0);
         if (vecs[i].exp_wr) begin
            check($sformatf("vec%0d_wr_addr", i), wr_addr_last, vecs[i].wr_addr);
            check($sformatf("vec%0d_wr_data", i), wr_data_last, vecs[i].wr_data);
         end
         check($sformatf("vec%0d_pops", i), pop_cnt - pop0, vecs[i].exp_pops);
      end
      end_frame();

      // Byte arriving while deselected is ignored.
      tx0 = tx_cnt; pop0 = pop_cnt;
      send_byte(8'h03, sc);
      check("deselected_no_tx", tx_cnt - tx0, 0);
      check("deselected_no_pop", pop_cnt - pop0, 0);

      // Abort a write after opcode and address.
      start_frame();
      wr0 = wr_cnt;
      send_byte(8'h02, sc);
      send_byte(8'h05, sc);
      end_frame();
      check("abort_no_write", wr_cnt - wr0, 0);
      check("abort_reg5_kept", regs[5], 8'hA5);
      start_frame();
      tx0 = tx_cnt;
      send_byte(8'h00, sc);
      check("abort_next_tx_count", tx_cnt - tx0, 1);
      check("abort_next_status", tx_last, 8'h01);

      // Async reset mid FIFO_STREAM, chip select held low throughout.
      end_frame();
      start_frame();
      send_byte(8'h03, sc);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {bus.tx_data, bus.tx_strobe, bus.reg_addr, bus.reg_wr_data, bus.reg_wr_strobe, bus.fifo_rd_strobe},
            32'h0);
      tick(1);
      reset_n = 1'b1;
      tick(4);
      tx0 = tx_cnt; pop0 = pop_cnt;
      send_byte(8'h00, sc);
      check("post_reset_tx_count", tx_cnt - tx0, 1);
      check("post_reset_status", tx_last, 8'h01);
      check("post_reset_latency", tx_cyc - sc, 1);
      check("post_reset_no_pop", pop_cnt - pop0, 0);
      end_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
